// File: rtl/err_mon_pkg.sv
// Shared types and helpers for the error event monitor.
// Default widths here describe the record layout for the stock 9-channel configuration.
package err_mon_pkg;

    localparam int unsigned NumErrDefault    = 9;
    localparam int unsigned CntWDefault      = 16;
    localparam int unsigned TsWDefault       = 32;
    localparam int unsigned FifoDepthDefault = 4;

    // $clog2 that never returns 0, so a single-channel build still has a 1-bit index
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned IdxWDefault = clog2_min1(NumErrDefault);

    typedef struct packed {
        logic [IdxWDefault-1:0] idx;
        logic [TsWDefault-1:0]  ts;
        logic [CntWDefault-1:0] count;
    } err_evt_t;

endpackage

// File: rtl/prim_fifo_sync.sv
// Synchronous valid/ready FIFO with synchronous clear; read data comes straight from storage.
// Pass=1 forwards a write to the read side when the FIFO is empty.
module prim_fifo_sync #(
    parameter int unsigned Width = 8,
    parameter bit          Pass  = 1'b0,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             wvalid_i,
    input  logic [Width-1:0] wdata_i,
    output logic             rvalid_o,
    input  logic             rready_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o
);
    localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned PtrW1 = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW:0]    wptr_q, rptr_q;
    logic             empty, pass_thru, wr_en, rd_en;

    // Extra pointer bit distinguishes full from empty
    assign empty     = (wptr_q == rptr_q);
    assign full_o    = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                       (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    assign pass_thru = Pass && empty && wvalid_i;
    assign rvalid_o  = !empty || pass_thru;
    assign rdata_o   = pass_thru ? wdata_i : mem_q[rptr_q[PtrW-1:0]];
    assign rd_en     = rready_i && !empty;
    assign wr_en     = wvalid_i && (!full_o || rd_en) && !(pass_thru && rready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
                wptr_q <= wptr_q + PtrW1'(1);
            end
            if (rd_en) begin
                rptr_q <= rptr_q + PtrW1'(1);
            end
        end
    end

endmodule

// File: rtl/err_event_monitor.sv
// Rising-edge monitor for N error lines: sticky flags, saturating counters,
// and a queue of timestamped event records drained over valid/ready.
module err_event_monitor
    import err_mon_pkg::*;
#(
    parameter int unsigned NumErr    = NumErrDefault,
    parameter int unsigned CntW      = CntWDefault,
    parameter int unsigned TsW       = TsWDefault,
    parameter int unsigned FifoDepth = FifoDepthDefault,
    parameter bit          ReportAll = 1'b0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic [NumErr-1:0]             err_i,
    output logic [NumErr-1:0]             errored_o,
    output logic                          evt_valid_o,
    input  logic                          evt_ready_i,
    output logic [clog2_min1(NumErr)-1:0] evt_idx_o,
    output logic [TsW-1:0]                evt_time_o,
    output logic [CntW-1:0]               evt_count_o,
    output logic                          overflow_o
);
    localparam int unsigned IdxW = clog2_min1(NumErr);
    localparam int unsigned EvtW = IdxW + TsW + CntW;

    logic [TsW-1:0]    ts_q;
    logic [NumErr-1:0] err_q, errored_q, pend_q;
    logic [CntW-1:0]   cnt_q  [NumErr];
    logic [CntW-1:0]   cnt_inc[NumErr];
    logic [TsW-1:0]    pts_q  [NumErr];
    logic [CntW-1:0]   pcnt_q [NumErr];
    logic              overflow_q;

    logic [NumErr-1:0] rise, ev, sel_oh, pend_clr;
    logic              sel_valid, push, fifo_full;
    logic [IdxW-1:0]   sel_idx;
    logic [TsW-1:0]    sel_ts;
    logic [CntW-1:0]   sel_cnt;
    logic [EvtW-1:0]   fifo_rdata;

    assign rise = err_i & ~err_q;
    assign ev   = rise & ({NumErr{ReportAll}} | ~errored_q);

    always_comb begin
        for (int i = 0; i < int'(NumErr); i++) begin
            cnt_inc[i] = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + CntW'(1);
        end
    end

    // Fixed-priority arbiter: lowest pending channel wins
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_ts    = '0;
        sel_cnt   = '0;
        sel_oh    = '0;
        for (int i = int'(NumErr) - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_valid = 1'b1;
                sel_idx   = IdxW'(i);
                sel_ts    = pts_q[i];
                sel_cnt   = pcnt_q[i];
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
        end
    end

    assign push     = sel_valid && !fifo_full;
    assign pend_clr = sel_oh & {NumErr{push}};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_q       <= '0;
            err_q      <= '0;
            errored_q  <= '0;
            pend_q     <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(NumErr); i++) begin
                cnt_q[i]  <= '0;
                pts_q[i]  <= '0;
                pcnt_q[i] <= '0;
            end
        end else begin
            ts_q  <= ts_q + TsW'(1);
            err_q <= err_i;
            if (clear_i) begin
                errored_q  <= '0;
                pend_q     <= '0;
                overflow_q <= 1'b0;
                for (int i = 0; i < int'(NumErr); i++) begin
                    cnt_q[i] <= '0;
                end
            end else begin
                errored_q <= errored_q | rise;
                // A new event replaces a pending one only if that one is leaving this cycle
                pend_q    <= (pend_q & ~pend_clr) | ev;
                for (int i = 0; i < int'(NumErr); i++) begin
                    if (rise[i]) begin
                        cnt_q[i] <= cnt_inc[i];
                    end
                    if (ev[i] && pend_q[i] && !pend_clr[i]) begin
                        overflow_q <= 1'b1;
                    end else if (ev[i]) begin
                        pts_q[i]  <= ts_q;
                        pcnt_q[i] <= cnt_inc[i];
                    end
                end
            end
        end
    end

    prim_fifo_sync #(
        .Width (EvtW),
        .Pass  (1'b0),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (clear_i),
        .wvalid_i (push),
        .wdata_i  ({sel_idx, sel_ts, sel_cnt}),
        .rvalid_o (evt_valid_o),
        .rready_i (evt_ready_i),
        .rdata_o  (fifo_rdata),
        .full_o   (fifo_full)
    );

    assign {evt_idx_o, evt_time_o, evt_count_o} = fifo_rdata;
    assign errored_o  = errored_q;
    assign overflow_o = overflow_q;

endmodule
